// File: rtl/prng_slice_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : prng_slice_arbiter_if
// Brief    : PRNG-side, requester-side and slice-side signals of the slice arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface prng_slice_arbiter_if #(
    parameter int LEN_PRNG = 256,
    parameter int N_REQ    = 3,
    parameter int CNT_W    = 16
) ();
    logic                      prng_valid_i;
    logic                      prng_ready_o;
    logic [LEN_PRNG-1:0]       prng_data_i;
    logic [N_REQ-1:0]          req_valid_i;
    logic [N_REQ-1:0][2:0]     req_width_i;
    logic [N_REQ-1:0]          req_ready_o;
    logic                      rnd_valid_o;
    logic                      rnd_ready_i;
    logic [LEN_PRNG-1:0]       rnd_data_o;
    logic [N_REQ-1:0]          rnd_owner_o;
    logic [2:0]                rnd_width_o;
    logic [CNT_W-1:0]          discard_cnt_o;

    // Arbiter side.
    modport master (
        input  prng_valid_i, prng_data_i, req_valid_i, req_width_i, rnd_ready_i,
        output prng_ready_o, req_ready_o, rnd_valid_o, rnd_data_o, rnd_owner_o,
        rnd_width_o, discard_cnt_o
    );

    // PRNG / consumer side.
    modport slave (
        output prng_valid_i, prng_data_i, req_valid_i, req_width_i, rnd_ready_i,
        input  prng_ready_o, req_ready_o, rnd_valid_o, rnd_data_o, rnd_owner_o,
        rnd_width_o, discard_cnt_o
    );
endinterface
`default_nettype wire

// File: rtl/prng_slice_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : prng_slice_arbiter
// Brief    : Buffers one PRNG word and hands round-robin slices to a/b/e.
// Revision : 1.0 - initial release
// ============================================================================
module prng_slice_arbiter #(
    parameter int LEN_PRNG = 256,
    parameter int N_REQ    = 3,
    parameter int CNT_W    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    prng_slice_arbiter_if.master bus
);
    localparam int N_UNITS = LEN_PRNG / 32;
    localparam int LVL_W   = $clog2(N_UNITS + 1);
    localparam int RR_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        S_FILL  = 2'd0,
        S_ARB   = 2'd1,
        S_ISSUE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [LEN_PRNG-1:0] buf_q, buf_d;
    logic [LVL_W-1:0]    level_q, level_d;
    logic [RR_W-1:0]     rr_q, rr_d;
    logic [LEN_PRNG-1:0] data_q, data_d;
    logic [N_REQ-1:0]    owner_q, owner_d;
    logic [2:0]          width_q, width_d;
    logic [CNT_W-1:0]    discard_q, discard_d;

    logic                found;
    logic [RR_W-1:0]     winner;
    logic [RR_W-1:0]     idx;
    logic [2:0]          win_width;
    logic [LVL_W-1:0]    u;
    logic [LEN_PRNG-1:0] slice_mask;
    logic [CNT_W:0]      disc_sum;
    logic [N_REQ-1:0]    req_ready;

    // Non-canonical width codes resolve by priority of the widest set bit.
    function automatic logic [LVL_W-1:0] units_of(input logic [2:0] w);
        if (w[2])      return LVL_W'(8);
        else if (w[1]) return LVL_W'(4);
        else if (w[0]) return LVL_W'(2);
        else           return LVL_W'(1);
    endfunction

    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = RR_W'((int'(rr_q) + i) % N_REQ);
            if (!found && bus.req_valid_i[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    assign win_width = bus.req_width_i[winner];
    assign u         = units_of(win_width);
    assign disc_sum  = {1'b0, discard_q} + (CNT_W+1)'(level_q);

    always_comb begin
        slice_mask = '0;
        for (int k = 0; k < N_UNITS; k++) begin
            slice_mask[k*32 +: 32] = (LVL_W'(k) < u) ? 32'hFFFF_FFFF : 32'h0;
        end
    end

    always_comb begin
        state_d   = state_q;
        buf_d     = buf_q;
        level_d   = level_q;
        rr_d      = rr_q;
        data_d    = data_q;
        owner_d   = owner_q;
        width_d   = width_q;
        discard_d = discard_q;
        req_ready = '0;
        case (state_q)
            S_FILL: begin
                if (bus.prng_valid_i) begin
                    buf_d   = bus.prng_data_i;
                    level_d = LVL_W'(N_UNITS);
                    state_d = S_ARB;
                end
            end
            S_ARB: begin
                if (found) begin
                    if (u <= level_q) begin
                        req_ready[winner] = 1'b1;
                        data_d  = buf_q & slice_mask;
                        owner_d = N_REQ'(1) << winner;
                        width_d = win_width;
                        buf_d   = buf_q >> {u, 5'b00000};
                        level_d = level_q - u;
                        rr_d    = (winner == RR_W'(N_REQ-1)) ? '0 : winner + 1'b1;
                        state_d = S_ISSUE;
                    end else begin
                        // Leftover units cannot serve the winner; drop them and keep rr so it wins after refill.
                        discard_d = disc_sum[CNT_W] ? '1 : disc_sum[CNT_W-1:0];
                        level_d   = '0;
                        state_d   = S_FILL;
                    end
                end
            end
            S_ISSUE: begin
                if (bus.rnd_ready_i) begin
                    state_d = (level_q != '0) ? S_ARB : S_FILL;
                end
            end
            default: state_d = S_FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FILL;
            buf_q     <= '0;
            level_q   <= '0;
            rr_q      <= '0;
            data_q    <= '0;
            owner_q   <= '0;
            width_q   <= '0;
            discard_q <= '0;
        end else begin
            state_q   <= state_d;
            buf_q     <= buf_d;
            level_q   <= level_d;
            rr_q      <= rr_d;
            data_q    <= data_d;
            owner_q   <= owner_d;
            width_q   <= width_d;
            discard_q <= discard_d;
        end
    end

    assign bus.prng_ready_o  = (state_q == S_FILL);
    assign bus.rnd_valid_o   = (state_q == S_ISSUE);
    assign bus.req_ready_o   = req_ready;
    assign bus.rnd_data_o    = data_q;
    assign bus.rnd_owner_o   = owner_q;
    assign bus.rnd_width_o   = width_q;
    assign bus.discard_cnt_o = discard_q;
endmodule
`default_nettype wire

// File: tb/tb_prng_slice_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_prng_slice_arbiter
// Brief    : Directed bench with a unit-queue reference model of the arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_prng_slice_arbiter;
    localparam int LEN_PRNG = 256;
    localparam int N_REQ    = 3;
    localparam int CNT_W    = 16;
    localparam int P_FILL   = 0;
    localparam int P_ARB    = 1;
    localparam int P_ISSUE  = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    prng_slice_arbiter_if #(.LEN_PRNG(LEN_PRNG), .N_REQ(N_REQ), .CNT_W(CNT_W)) bus ();

    prng_slice_arbiter #(.LEN_PRNG(LEN_PRNG), .N_REQ(N_REQ), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [255:0] words[$];
    int           hs_count = 0;
    int           hs_taken = 0;

    // Reference model: remaining buffered units as a queue, plus the presented slice.
    logic [31:0]  m_units[$];
    int           m_phase = P_FILL;
    int           m_rr    = 0;
    logic [255:0] m_data  = '0;
    logic [2:0]   m_owner = '0;
    logic [2:0]   m_width = '0;
    int           m_disc  = 0;
    bit           m_init  = 1'b0;

    function automatic logic [255:0] mk_word(input logic [31:0] base);
        logic [255:0] w;
        for (int k = 0; k < 8; k++) w[32*k +: 32] = base + 32'(k);
        return w;
    endfunction

    function automatic int units_of(input logic [2:0] w);
        if (w[2]) return 8;
        if (w[1]) return 4;
        if (w[0]) return 2;
        return 1;
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_step();
        int         win, u, j;
        logic [2:0] e_req;
        logic       e_valid, e_pready;
        win = -1; u = 0; j = 0; e_req = '0;
        if (m_phase == P_ARB) begin
            for (int i = 0; i < N_REQ; i++) begin
                j = (m_rr + i) % N_REQ;
                if (win < 0 && bus.req_valid_i[j]) win = j;
            end
            if (win >= 0) begin
                u = units_of(bus.req_width_i[win]);
                if (u <= m_units.size()) e_req[win] = 1'b1;
            end
        end
        e_valid  = (m_phase == P_ISSUE);
        e_pready = (m_phase == P_FILL);
        if (m_init) begin
            n_checks++;
            if (bus.rnd_valid_o !== e_valid || bus.prng_ready_o !== e_pready ||
                bus.req_ready_o !== e_req || bus.rnd_data_o !== m_data ||
                bus.rnd_owner_o !== m_owner || bus.rnd_width_o !== m_width ||
                bus.discard_cnt_o !== CNT_W'(m_disc)) begin
                n_errors++;
                $display("FAIL cycle_model t=%0t: got v=%b pr=%b rr=%b own=%b w=%b disc=%0d data=%h; expected v=%b pr=%b rr=%b own=%b w=%b disc=%0d data=%h",
                         $time, bus.rnd_valid_o, bus.prng_ready_o, bus.req_ready_o, bus.rnd_owner_o,
                         bus.rnd_width_o, bus.discard_cnt_o, bus.rnd_data_o,
                         e_valid, e_pready, e_req, m_owner, m_width, m_disc, m_data);
            end
        end
        if (!rst && bus.prng_valid_i && bus.prng_ready_o) hs_count++;
        if (rst) begin
            m_units.delete();
            m_phase = P_FILL; m_rr = 0; m_data = '0; m_owner = '0; m_width = '0; m_disc = 0;
            m_init  = 1'b1;
        end else begin
            case (m_phase)
                P_FILL: if (bus.prng_valid_i) begin
                    m_units.delete();
                    for (int k = 0; k < 8; k++) m_units.push_back(bus.prng_data_i[32*k +: 32]);
                    m_phase = P_ARB;
                end
                P_ARB: if (win >= 0) begin
                    if (e_req != '0) begin
                        m_data = '0;
                        for (int k = 0; k < u; k++) m_data[32*k +: 32] = m_units.pop_front();
                        m_owner = e_req;
                        m_width = bus.req_width_i[win];
                        m_rr    = (win + 1) % N_REQ;
                        m_phase = P_ISSUE;
                    end else begin
                        m_disc = m_disc + m_units.size();
                        if (m_disc > (1 << CNT_W) - 1) m_disc = (1 << CNT_W) - 1;
                        m_units.delete();
                        m_phase = P_FILL;
                    end
                end
                P_ISSUE: if (bus.rnd_ready_i) m_phase = (m_units.size() > 0) ? P_ARB : P_FILL;
                default: m_phase = P_FILL;
            endcase
        end
    endtask

    task automatic update_feed();
        bus.prng_valid_i = (words.size() > 0);
        bus.prng_data_i  = (words.size() > 0) ? words[0] : '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        while (hs_taken < hs_count) begin
            words.delete(0);
            hs_taken++;
        end
        update_feed();
    endtask

    task automatic take(input int idx, input logic [2:0] w, input bit consume,
                        output logic [255:0] d, output logic [2:0] own, output logic [2:0] wd);
        int cyc;
        cyc = 0;
        bus.req_valid_i[idx] = 1'b1;
        bus.req_width_i[idx] = w;
        while (bus.rnd_valid_o !== 1'b1 && cyc < 40) begin
            tick();
            cyc++;
        end
        chk("grant_in_time", 256'(cyc < 40), 256'd1);
        bus.req_valid_i[idx] = 1'b0;
        d   = bus.rnd_data_o;
        own = bus.rnd_owner_o;
        wd  = bus.rnd_width_o;
        if (consume) begin
            bus.rnd_ready_i = 1'b1;
            tick();
            bus.rnd_ready_i = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
    endtask

    initial begin
        logic [255:0] d;
        logic [2:0]   own, wd;
        logic [2:0]   rr_own[4];
        logic [31:0]  rr_dat[4];
        int           got, cyc;

        bus.prng_valid_i = 1'b0;
        bus.prng_data_i  = '0;
        bus.req_valid_i  = '0;
        bus.req_width_i  = '0;
        bus.rnd_ready_i  = 1'b0;

        fork
            forever begin
                @(negedge clk);
                model_step();
            end
        join_none

        // Reset state and single 32-bit / 64-bit slices from W0.
        do_reset();
        chk("reset_state", {bus.prng_ready_o, bus.rnd_valid_o, bus.req_ready_o, bus.discard_cnt_o},
            {1'b1, 1'b0, 3'b000, 16'd0});
        words.push_back(mk_word(32'h0)); update_feed();
        take(0, 3'b000, 1'b1, d, own, wd);
        chk("a32_data", d, 256'h0);
        chk("a32_owner", 256'(own), 256'(3'b001));
        take(1, 3'b001, 1'b1, d, own, wd);
        chk("b64_data", d, 256'h00000002_00000001);
        chk("b64_owner_width", 256'({own, wd}), 256'({3'b010, 3'b001}));

        // Non-canonical width 100 with 5 units left: discard 5, refill, full word to e.
        words.push_back(mk_word(32'hA5A5_0000)); update_feed();
        take(2, 3'b100, 1'b1, d, own, wd);
        chk("nc_data", d, mk_word(32'hA5A5_0000));
        chk("nc_owner_width", 256'({own, wd}), 256'({3'b100, 3'b100}));
        chk("nc_discard", 256'(bus.discard_cnt_o), 256'd5);

        // Round-robin from a fresh word.
        do_reset();
        chk("reset2_discard", 256'(bus.discard_cnt_o), 256'd0);
        words.push_back(mk_word(32'h0)); update_feed();
        bus.req_valid_i = 3'b111;
        bus.req_width_i = '0;
        bus.rnd_ready_i = 1'b1;
        got = 0; cyc = 0;
        while (got < 4 && cyc < 60) begin
            tick();
            cyc++;
            if (bus.rnd_valid_o === 1'b1) begin
                rr_own[got] = bus.rnd_owner_o;
                rr_dat[got] = bus.rnd_data_o[31:0];
                got++;
            end
        end
        tick();
        bus.req_valid_i = '0;
        bus.rnd_ready_i = 1'b0;
        chk("rr_count", 256'(got), 256'd4);
        chk("rr_owners", 256'({rr_own[0], rr_own[1], rr_own[2], rr_own[3]}),
            256'({3'b001, 3'b010, 3'b100, 3'b001}));
        chk("rr_data", 256'({rr_dat[0], rr_dat[1], rr_dat[2], rr_dat[3]}),
            256'({32'd0, 32'd1, 32'd2, 32'd3}));

        // Backpressure: b holds slice unit 4 while every requester is valid.
        take(1, 3'b000, 1'b0, d, own, wd);
        bus.req_valid_i = 3'b111;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_hold", 256'({bus.rnd_valid_o, bus.rnd_owner_o, bus.req_ready_o, bus.prng_ready_o, bus.rnd_data_o[31:0]}),
                256'({1'b1, 3'b010, 3'b000, 1'b0, 32'd4}));
        end
        bus.req_valid_i = '0;
        bus.rnd_ready_i = 1'b1;
        tick();
        bus.rnd_ready_i = 1'b0;

        // Discard-and-refill: 3 units left, a asks for 256 bits.
        words.push_back(mk_word(32'h1234_5600)); update_feed();
        take(0, 3'b111, 1'b1, d, own, wd);
        chk("disc_data", d, mk_word(32'h1234_5600));
        chk("disc_owner_width", 256'({own, wd}), 256'({3'b001, 3'b111}));
        chk("disc_count", 256'(bus.discard_cnt_o), 256'd3);

        // Reset while a slice is pending with 5 units buffered.
        words.push_back(mk_word(32'h3000_0000)); update_feed();
        take(0, 3'b000, 1'b1, d, own, wd);
        chk("w3_a32", d, 256'h30000000);
        take(1, 3'b001, 1'b0, d, own, wd);
        chk("w3_b64", d, 256'h30000002_30000001);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_reset", 256'({bus.rnd_valid_o, bus.prng_ready_o, bus.discard_cnt_o}),
            256'({1'b0, 1'b1, 16'd0}));
        words.push_back(mk_word(32'h4000_0000)); update_feed();
        take(0, 3'b000, 1'b1, d, own, wd);
        chk("post_reset_unit0", d, 256'h40000000);
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/prng_slice_arbiter.md
Name: prng_slice_arbiter

Overview:
- Shares one 256-bit PRNG output stream among the three correlated-randomness consumers: a, b and e. Bit order is req_*[0]=a, [1]=b, [2]=e.
- Each consumer asks for a slice of 32, 64, 128 or 256 bits, using the lane-width encoding of the CRG datapath (is256/is128/is64).
- The block buffers one PRNG word and dispenses slices from its LSB end. It arbitrates round-robin and refills from the PRNG through a valid/ready handshake.
- It sits between the PRNG core and the a/b/e share-generation datapaths.

Parameters:
- LEN_PRNG, 256, PRNG word width. Must be 8 x 32.
- N_REQ, 3, number of requesters (a, b, e).
- CNT_W, 16, width of the discard counter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- prng_valid_i  in  1  PRNG word available.
- prng_ready_o  out  1  block accepts a PRNG word.
- prng_data_i  in  256  PRNG word.
- req_valid_i  in  3  per-requester request.
- req_width_i  in  3x3  per-requester width, bit order {is256,is128,is64}.
- req_ready_o  out  3  one-hot request accept.
- rnd_valid_o  out  1  slice valid.
- rnd_ready_i  in  1  slice consumed.
- rnd_data_o  out  256  slice, zero-extended.
- rnd_owner_o  out  3  one-hot owner of the slice.
- rnd_width_o  out  3  width of the slice, same encoding as req_width_i.
- discard_cnt_o  out  CNT_W  saturating count of discarded 32-bit units.

Behaviour:
- Units per width: is256 gives 8; else is128 gives 4; else is64 gives 2; else 1. Non-canonical codes resolve by this priority.
- State: buf (256 bits), level (0..8 units), rr pointer, FSM state.
- FSM states: FILL, ARB, ISSUE.
- Reset values: state=FILL, level=0, buf=0, rr=0 (a has highest priority), rnd_valid_o=0, rnd_data_o=0, rnd_owner_o=0, rnd_width_o=0, req_ready_o=0, discard_cnt_o=0.
- Reset mid-operation:
  - Buffered bits and any pending slice are dropped.
  - rnd_valid_o is low in the cycle after rst is sampled.
- FILL:
  - prng_ready_o=1; it is 0 in every other state.
  - On prng_valid_i: buf<=prng_data_i, level<=8, go to ARB.
- ARB, no req_valid_i set: stay in ARB, buf and level held.
- ARB, winner selection: the winner is the first valid requester, searching from index rr upward with wrap-around. Its unit count is u.
- ARB, u<=level:
  - req_ready_o[winner]=1 for exactly this cycle (combinational, ARB only).
  - rnd_data_o<=buf masked to its low 32u bits.
  - rnd_owner_o<=onehot(winner), rnd_width_o<=req_width_i[winner].
  - buf<=buf>>32u, level<=level-u.
  - rr<=(winner+1) mod 3.
  - Go to ISSUE.
- ARB, u>level:
  - Remaining units are discarded: discard_cnt_o+=level, saturating at all-ones.
  - level<=0, go to FILL. rr is unchanged, so the same requester wins after refill if still valid.
  - No req_ready_o is raised.
- ISSUE:
  - rnd_valid_o=1; data, owner and width held stable until rnd_ready_i.
  - On rnd_ready_i: rnd_valid_o<=0, then go to ARB if level>0, else FILL.
- Latency:
  - Request present in ARB with enough units: rnd_valid_o rises on the next cycle.
  - From FILL to slice: PRNG handshake, then 1 ARB cycle, then ISSUE.
- A requester's width is sampled only in the accept cycle. Requests are not cancelable once accepted.
- Simultaneous requests are resolved only through rr. A requester holding valid is served within 3 grants.
- Slices are never split across PRNG words. Bits are never reused.

Test Plan:
- Single 32-bit request:
  - Stimulus: PRNG word W0 with unit k = k (0x00000007_..._00000000); only a valid, width 000.
  - Response: req_ready_o=001 one cycle, then rnd_data_o=0x0, owner 001, level 7.
  - Follow-on: b requests width 001 → rnd_data_o=0x00000002_00000001, level 5.
- Round-robin:
  - Stimulus: a, b and e all hold valid, width 000, rnd_ready_i=1.
  - Response: owners issued a, b, e, a, ...; data 0, 1, 2, 3; a 4th grant follows with no refill.
- Discard and refill:
  - Stimulus: after one 32-bit grant (level 7), a requests width 111.
  - Response: discard_cnt_o=7, prng_ready_o=1; with next word W1, rnd_data_o=W1 in full, level 0, then FILL.
- Backpressure:
  - Stimulus: rnd_ready_i=0 for 10 cycles during ISSUE.
  - Response: rnd_valid_o, data and owner stable; no req_ready_o; prng_ready_o=0.
- Reset mid-operation:
  - Stimulus: assert rst during ISSUE with level=5.
  - Response: next cycle rnd_valid_o=0, prng_ready_o=1, discard_cnt_o=0; first grant after the new word comes from unit 0.
- Non-canonical width:
  - Stimulus: width 100.
  - Response: 8 units consumed, rnd_width_o=100.
